// File: rtl/log_drain_if.sv
// Shared bus between the log drain, the logger's log RAM (port B read side,
// write pointer/strobe observation, clear pulse) and the byte sink.
interface log_drain_if #(
    parameter int REC_W  = 37,
    parameter int ADDR_W = 16
);
    // Logger side: write pointer and write strobe observed by the drain
    logic [ADDR_W-1:0] wr_addr;
    logic              we;
    // RAM port B read side
    logic              re;
    logic [ADDR_W-1:0] rd_addr;
    logic [REC_W-1:0]  rd_data;
    // Clear pulse to the logger
    logic              clr_ram;
    // Byte stream towards the sink
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    // The drain block itself
    modport master (
        input  wr_addr, we, rd_data, tx_ready,
        output re, rd_addr, clr_ram, tx_data, tx_valid
    );

    // Environment: logger, RAM and sink
    modport slave (
        output wr_addr, we, rd_data, tx_ready,
        input  re, rd_addr, clr_ram, tx_data, tx_valid
    );
endinterface

// File: rtl/log_drain.sv
// Drains the violation-log ring RAM and streams each 37-bit record as a
// 7-byte frame: SYNC, five record bytes (MS first, zero-padded to 40 bits),
// and an XOR checksum over the five record bytes.
module log_drain #(
    parameter int          REC_W  = 37,
    parameter int          ADDR_W = 16,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         drain_en_i,
    input  logic         clear_req_i,
    log_drain_if.master  bus,
    output logic         busy_o,
    output logic         overflow_o,
    output logic [15:0]  frames_sent_o
);

    localparam int         WORD_W   = 40;
    localparam logic [2:0] LAST_IDX = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        SEND,
        CLEAR
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic                clr_pend_q;
    logic                re_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                clr_ram_q;
    logic [7:0]          tx_data_q;
    logic                tx_valid_q;
    logic                busy_q;
    logic                overflow_q;
    logic [15:0]         frames_q;
    logic [WORD_W-1:0]   word_q;
    logic [7:0]          ck_q;
    logic [2:0]          idx_q;

    logic                pending_d;
    logic                ovf_hit_d;
    logic [ADDR_W-1:0]   wr_next_d;
    logic [WORD_W-1:0]   word_d;
    logic [7:0]          ck_d;
    logic                tx_fire_d;

    // Byte at a given frame position: 0 = SYNC, 1..5 = record bytes, 6 = checksum
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [WORD_W-1:0] w,
                                              input logic [7:0] ck);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC;
            3'd1:    b = w[39:32];
            3'd2:    b = w[31:24];
            3'd3:    b = w[23:16];
            3'd4:    b = w[15:8];
            3'd5:    b = w[7:0];
            default: b = ck;
        endcase
        return b;
    endfunction

    // Ring status, overflow detection and the word/checksum built from RAM data
    always_comb begin
        // NOTE: every variable gets a value on every path of a combinational block, otherwise a latch is inferred.
        wr_next_d = bus.wr_addr + ADDR_W'(1);
        pending_d = (rd_ptr_q != bus.wr_addr);
        ovf_hit_d = bus.we && (wr_next_d == rd_ptr_q);
        word_d    = {{(WORD_W - REC_W){1'b0}}, bus.rd_data};
        ck_d      = word_d[39:32] ^ word_d[31:24] ^ word_d[23:16] ^ word_d[15:8] ^ word_d[7:0];
        tx_fire_d = tx_valid_q && bus.tx_ready;
    end

    // Drain FSM with all outputs registered; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            clr_pend_q <= 1'b0;
            re_q       <= 1'b0;
            rd_addr_q  <= '0;
            clr_ram_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            frames_q   <= '0;
            // NOTE: the frame word and checksum are ordinary flops (not a RAM array), so they are reset along with the rest.
            word_q     <= '0;
            ck_q       <= '0;
            idx_q      <= '0;
        end else begin
            // Overflow is sticky; the clear cycle wins, so a write racing the clear pulse is never flagged
            if (state_q == CLEAR) begin
                overflow_q <= 1'b0;
            end else if (ovf_hit_d) begin
                // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
                overflow_q <= 1'b1;
            end

            // Clear requests are held until the FSM returns to IDLE
            if (state_q != CLEAR && clear_req_i) begin
                clr_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (clr_pend_q) begin
                        state_q   <= CLEAR;
                        clr_ram_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (drain_en_i && !overflow_q && pending_d) begin
                        state_q   <= READ;
                        re_q      <= 1'b1;
                        rd_addr_q <= rd_ptr_q;
                        busy_q    <= 1'b1;
                    end
                end
                READ: begin
                    re_q    <= 1'b0;
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    word_q     <= word_d;
                    ck_q       <= ck_d;
                    rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
                    tx_data_q  <= SYNC;
                    tx_valid_q <= 1'b1;
                    idx_q      <= '0;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (tx_fire_d) begin
                        if (idx_q == LAST_IDX) begin
                            tx_valid_q <= 1'b0;
                            frames_q   <= frames_q + 16'd1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            tx_data_q <= frame_byte(idx_q + 3'd1, word_q, ck_q);
                        end
                    end
                end
                CLEAR: begin
                    clr_ram_q  <= 1'b0;
                    rd_ptr_q   <= '0;
                    frames_q   <= '0;
                    clr_pend_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    re_q       <= 1'b0;
                    clr_ram_q  <= 1'b0;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.re        = re_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.clr_ram   = clr_ram_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign busy_o        = busy_q;
    assign overflow_o    = overflow_q;
    assign frames_sent_o = frames_q;

endmodule

// File: tb/tb_log_drain.sv
// Self-checking bench for log_drain: directed frame/backpressure/reset/
// overflow/clear scenarios plus a randomized drain phase, with a reference
// model that rebuilds every expected frame from the record contents.
module tb_log_drain;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        drain_en;
    logic        clear_req;
    logic        busy;
    logic        overflow;
    logic [15:0] frames_sent;

    log_drain_if bus ();

    log_drain dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .drain_en_i    (drain_en),
        .clear_req_i   (clear_req),
        .bus           (bus),
        .busy_o        (busy),
        .overflow_o    (overflow),
        .frames_sent_o (frames_sent)
    );

    always #5 clk = ~clk;

    // Log RAM port B: data valid one cycle after re
    logic [36:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.re) bus.rd_data <= mem[bus.rd_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: read pointer, expected byte stream, frame count
    logic [7:0]  exp_q [$];
    logic [15:0] m_rd_ptr;
    logic [15:0] m_frames;
    int          pos;
    logic        stall_prev;
    logic [7:0]  prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_rd_ptr   = '0;
            m_frames   = '0;
            pos        = 0;
            stall_prev = 1'b0;
        end else begin
            if (bus.clr_ram) begin
                check("clr_after_whole_frame", pos, 0);
                check("clr_no_tx", bus.tx_valid, 1'b0);
                m_rd_ptr = '0;
                m_frames = '0;
            end
            if (bus.re) begin
                logic [39:0] w;
                logic [7:0]  b;
                logic [7:0]  ck;
                check("re_tx_exclusive", bus.tx_valid, 1'b0);
                check("rd_addr", bus.rd_addr, m_rd_ptr);
                w  = {3'b000, mem[m_rd_ptr]};
                ck = 8'h00;
                exp_q.push_back(SYNC);
                for (int k = 4; k >= 0; k--) begin
                    b = w[8*k +: 8];
                    exp_q.push_back(b);
                    ck = ck ^ b;
                end
                exp_q.push_back(ck);
                m_rd_ptr = m_rd_ptr + 16'd1;
            end
            if (stall_prev) begin
                check("hold_valid", bus.tx_valid, 1'b1);
                check("hold_data", bus.tx_data, prev_data);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) check("tx_unexpected_byte", 1, 0);
                else                   check("tx_byte", bus.tx_data, exp_q.pop_front());
                pos++;
                if (pos == 7) begin
                    pos = 0;
                    m_frames = m_frames + 16'd1;
                end
            end
            stall_prev = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input int budget, input string tag);
        int n = 0;
        while ((busy || m_rd_ptr != bus.wr_addr) && n < budget) begin
            step();
            n++;
        end
        check(tag, n < budget, 1'b1);
    endtask

    task automatic wait_clr(input int budget, input string tag);
        int n = 0;
        while (!bus.clr_ram && n < budget) begin
            step();
            n++;
        end
        check(tag, bus.clr_ram, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_re"}, bus.re, 1'b0);
        check({tag, "_rd_addr"}, bus.rd_addr, 16'h0);
        check({tag, "_clr_ram"}, bus.clr_ram, 1'b0);
        check({tag, "_tx_data"}, bus.tx_data, 8'h00);
        check({tag, "_tx_valid"}, bus.tx_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_frames"}, frames_sent, 16'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dir [7];
        logic       saw_read;
        int         n;
        dir = '{8'hA5, 8'h1A, 8'hBC, 8'hDE, 8'hF0, 8'h12, 8'h9A};

        rst_n = 1'b0; drain_en = 1'b0; clear_req = 1'b0;
        bus.wr_addr = '0; bus.we = 1'b0; bus.tx_ready = 1'b0;
        repeat (2) step();
        check_all_zero("por");
        rst_n = 1'b1;
        step();

        // Single record with exact cycle timing
        mem[0] = 37'h1A_BCDE_F012;
        bus.wr_addr = 16'd1; drain_en = 1'b1; bus.tx_ready = 1'b1;
        step();
        check("t2_re", bus.re, 1'b1);
        check("t2_rd_addr", bus.rd_addr, 16'd0);
        check("t2_busy", busy, 1'b1);
        step();
        check("t2_re_low", bus.re, 1'b0);
        step();
        check("t2_valid", bus.tx_valid, 1'b1);
        check("t2_b0", bus.tx_data, dir[0]);
        for (int k = 1; k < 7; k++) begin
            step();
            check("t2_valid", bus.tx_valid, 1'b1);
            check("t2_byte", bus.tx_data, dir[k]);
        end
        step();
        check("t2_valid_end", bus.tx_valid, 1'b0);
        check("t2_frames", frames_sent, 16'd1);
        check("t2_busy_end", busy, 1'b0);

        // Backpressure while B2 is presented
        mem[1] = 37'h1A_BCDE_F012;
        bus.wr_addr = 16'd2;
        repeat (6) step();
        check("t3_b2", bus.tx_data, 8'hDE);
        bus.tx_ready = 1'b0;
        repeat (5) begin
            step();
            check("t3_hold_data", bus.tx_data, 8'hDE);
            check("t3_hold_valid", bus.tx_valid, 1'b1);
        end
        bus.tx_ready = 1'b1;
        for (int k = 4; k < 7; k++) begin
            step();
            check("t3_byte", bus.tx_data, dir[k]);
        end
        step();
        check("t3_frames", frames_sent, 16'd2);
        check("t3_busy_end", busy, 1'b0);

        // Randomized writes, sink readiness and drain enable
        for (int r = 0; r < 20; r++) begin
            mem[bus.wr_addr] = {$urandom_range(0, 31), $urandom()};
            bus.we = 1'b1;
            step();
            bus.we = 1'b0;
            bus.wr_addr = bus.wr_addr + 16'd1;
            repeat ($urandom_range(0, 12)) begin
                step();
                bus.tx_ready = ($urandom_range(0, 3) != 0);
                drain_en     = ($urandom_range(0, 3) != 0);
            end
        end
        drain_en = 1'b1; bus.tx_ready = 1'b1;
        wait_drained(600, "rand_drain_done");
        check("rand_frames", frames_sent, m_frames);
        check("rand_overflow", overflow, 1'b0);

        // Reset in the middle of a frame
        mem[bus.wr_addr] = {$urandom_range(0, 31), $urandom()};
        bus.wr_addr = bus.wr_addr + 16'd1;
        repeat (5) step();
        check("t1_mid_send", bus.tx_valid, 1'b1);
        rst_n = 1'b0;
        bus.wr_addr = 16'd2;
        repeat (2) step();
        check_all_zero("t1_rst");
        rst_n = 1'b1;
        n = 0;
        while (!bus.tx_valid && n < 10) begin
            step();
            n++;
        end
        check("t1_resync_valid", bus.tx_valid, 1'b1);
        check("t1_resync_sync", bus.tx_data, SYNC);
        wait_drained(100, "t1_drain_done");
        check("t1_frames", frames_sent, 16'd2);

        // Overflow: rd_ptr = 5, logger writes at wr_addr = 4
        for (int a = 2; a < 5; a++) mem[a] = {$urandom_range(0, 31), $urandom()};
        bus.wr_addr = 16'd5;
        wait_drained(100, "t5_prefill_done");
        drain_en = 1'b0;
        bus.wr_addr = 16'd4; bus.we = 1'b1;
        step();
        bus.we = 1'b0;
        check("t5_overflow", overflow, 1'b1);
        drain_en = 1'b1;
        saw_read = 1'b0;
        repeat (8) begin
            step();
            saw_read = saw_read | bus.re | busy;
        end
        check("t5_no_read", saw_read, 1'b0);
        check("t5_sticky", overflow, 1'b1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        wait_clr(8, "t5_clr_seen");
        check("t5_busy_clear", busy, 1'b1);
        step();
        bus.wr_addr = 16'd0;
        check("t5_clr_pulse", bus.clr_ram, 1'b0);
        check("t5_ovf_cleared", overflow, 1'b0);
        check("t5_frames_cleared", frames_sent, 16'd0);
        check("t5_busy_idle", busy, 1'b0);

        // Ring wrap of the overflow compare; a write racing the clear pulse is not flagged
        drain_en = 1'b0;
        bus.wr_addr = 16'hFFFE; bus.we = 1'b1;
        step();
        check("wrap_no_ovf", overflow, 1'b0);
        bus.wr_addr = 16'hFFFF;
        step();
        check("wrap_ovf", overflow, 1'b1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        wait_clr(8, "wrap_clr_seen");
        step();
        bus.we = 1'b0; bus.wr_addr = 16'd0;
        check("wrap_clr_we_no_ovf", overflow, 1'b0);

        // Clear requested during B1 is honoured only after the frame completes
        mem[0] = {$urandom_range(0, 31), $urandom()};
        bus.wr_addr = 16'd1; drain_en = 1'b1; bus.tx_ready = 1'b1;
        repeat (5) step();
        check("t6_in_frame", bus.tx_valid, 1'b1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("t6_no_early_clr", bus.clr_ram, 1'b0);
        wait_clr(20, "t6_clr_seen");
        check("t6_frame_counted", frames_sent, 16'd1);
        step();
        bus.wr_addr = 16'd0;
        check("t6_clr_pulse", bus.clr_ram, 1'b0);
        check("t6_frames_cleared", frames_sent, 16'd0);
        repeat (3) step();
        check("t6_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
